// File: rtl/riscv_defines.sv
// Shared definitions for the racetrack shift controller: state encoding and
// default sizing constants.
package riscv_defines;

  localparam int unsigned RT_CNT_WIDTH    = 10;
  localparam int unsigned RT_PULSE_CYCLES = 2;

  typedef enum logic [1:0] {
    RT_IDLE     = 2'd0,
    RT_PULSE_HI = 2'd1,
    RT_PULSE_LO = 2'd2,
    RT_DONE     = 2'd3
  } rt_shift_state_t;

endpackage

// File: rtl/rt_pulse_timer.sv
// Phase timer: loads PULSE_CYCLES-1 and counts down; the strobe marks the
// last cycle of the current pulse phase.
module rt_pulse_timer
  import riscv_defines::*;
#(
  parameter int unsigned PULSE_CYCLES = RT_PULSE_CYCLES
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic load_i,
  output logic phase_end_c_o
);

  localparam int unsigned TW = (PULSE_CYCLES > 1) ? $clog2(PULSE_CYCLES) : 1;

  logic [TW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = TW'(PULSE_CYCLES - 1);
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - TW'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign phase_end_c_o = (cnt_q == '0);

endmodule

// File: rtl/racetrack_shift_ctrl.sv
// Racetrack shift controller: turns port-set/port-reset requests into a shift
// pulse train, tracking track position and the per-access shift count.
module racetrack_shift_ctrl
  import riscv_defines::*;
#(
  parameter int unsigned CNT_WIDTH    = RT_CNT_WIDTH,
  parameter int unsigned PULSE_CYCLES = RT_PULSE_CYCLES
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 shift_en_s_i,
  input  logic                 shift_en_r_i,
  input  logic                 shift_dir_i,
  input  logic                 source_shift_sel_i,
  input  logic [CNT_WIDTH-1:0] n_shift_i,
  output logic                 shift_pulse_o,
  output logic                 shift_dir_o,
  output logic                 shift_done_s_o,
  output logic                 shift_done_r_o,
  output logic                 busy_o,
  output logic [CNT_WIDTH-1:0] pos_o,
  output logic                 err_o
);

  rt_shift_state_t      state_q, state_d;
  logic                 op_set_q, op_set_d;
  logic                 dir_q, dir_d;
  logic                 abort_q, abort_d;
  logic                 err_q, err_d;
  logic [CNT_WIDTH-1:0] count_q, count_d;
  logic [CNT_WIDTH-1:0] n_saved_q, n_saved_d;
  logic [CNT_WIDTH-1:0] pos_q, pos_d;
  logic [CNT_WIDTH-1:0] load_cnt;
  logic                 en_match;
  logic                 timer_load;
  logic                 phase_end;

  rt_pulse_timer #(
    .PULSE_CYCLES(PULSE_CYCLES)
  ) u_timer (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .load_i       (timer_load),
    .phase_end_c_o(phase_end)
  );

  // Next-state and datapath updates
  always_comb begin
    state_d    = state_q;
    op_set_d   = op_set_q;
    dir_d      = dir_q;
    abort_d    = abort_q;
    err_d      = err_q;
    count_d    = count_q;
    n_saved_d  = n_saved_q;
    pos_d      = pos_q;
    timer_load = 1'b0;
    load_cnt   = source_shift_sel_i ? n_saved_q : n_shift_i;
    en_match   = op_set_q ? shift_en_s_i : shift_en_r_i;

    unique case (state_q)
      RT_IDLE: begin
        if (shift_en_s_i || shift_en_r_i) begin
          // Set wins a conflict; the conflict itself is a protocol error
          op_set_d = shift_en_s_i;
          dir_d    = shift_dir_i;
          count_d  = load_cnt;
          abort_d  = 1'b0;
          if (shift_en_s_i) begin
            n_saved_d = n_shift_i;
          end
          if (shift_en_s_i && shift_en_r_i) begin
            err_d = 1'b1;
          end
          if (load_cnt == '0) begin
            state_d = RT_DONE;
          end else begin
            state_d    = RT_PULSE_HI;
            timer_load = 1'b1;
          end
        end
      end

      RT_PULSE_HI: begin
        if (!en_match) begin
          abort_d = 1'b1;
        end
        if (phase_end) begin
          state_d    = RT_PULSE_LO;
          timer_load = 1'b1;
        end
      end

      RT_PULSE_LO: begin
        if (!en_match) begin
          abort_d = 1'b1;
        end
        if (phase_end) begin
          count_d = count_q - CNT_WIDTH'(1);
          pos_d   = dir_q ? (pos_q + CNT_WIDTH'(1)) : (pos_q - CNT_WIDTH'(1));
          // An abort finishes the current pulse pair, then leaves without done
          if (abort_q || !en_match) begin
            state_d = RT_IDLE;
            err_d   = 1'b1;
          end else if (count_q == CNT_WIDTH'(1)) begin
            state_d = RT_DONE;
          end else begin
            state_d    = RT_PULSE_HI;
            timer_load = 1'b1;
          end
        end
      end

      RT_DONE: begin
        if (!en_match) begin
          state_d = RT_IDLE;
        end
      end

      default: state_d = RT_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= RT_IDLE;
      op_set_q  <= 1'b0;
      dir_q     <= 1'b0;
      abort_q   <= 1'b0;
      err_q     <= 1'b0;
      count_q   <= '0;
      n_saved_q <= '0;
      pos_q     <= '0;
    end else begin
      state_q   <= state_d;
      op_set_q  <= op_set_d;
      dir_q     <= dir_d;
      abort_q   <= abort_d;
      err_q     <= err_d;
      count_q   <= count_d;
      n_saved_q <= n_saved_d;
      pos_q     <= pos_d;
    end
  end

  // Status decoded straight from state so reset clears them immediately
  assign shift_pulse_o  = (state_q == RT_PULSE_HI);
  assign busy_o         = (state_q != RT_IDLE);
  assign shift_done_s_o = (state_q == RT_DONE) && op_set_q;
  assign shift_done_r_o = (state_q == RT_DONE) && !op_set_q;
  assign shift_dir_o    = dir_q;
  assign pos_o          = pos_q;
  assign err_o          = err_q;

endmodule

// File: tb/tb_racetrack_shift_ctrl.sv
// Directed bench for racetrack_shift_ctrl with PULSE_CYCLES=2, CNT_WIDTH=10.
module tb_racetrack_shift_ctrl;

  localparam int unsigned CW = 10;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          shift_en_s_i;
  logic          shift_en_r_i;
  logic          shift_dir_i;
  logic          source_shift_sel_i;
  logic [CW-1:0] n_shift_i;
  logic          shift_pulse_o;
  logic          shift_dir_o;
  logic          shift_done_s_o;
  logic          shift_done_r_o;
  logic          busy_o;
  logic [CW-1:0] pos_o;
  logic          err_o;

  int n_tests  = 0;
  int n_failed = 0;
  int pulses   = 0;
  int hi_cyc   = 0;
  int cyc      = 0;
  bit prev_pulse = 1'b0;
  bit done_seen  = 1'b0;

  racetrack_shift_ctrl #(
    .CNT_WIDTH   (CW),
    .PULSE_CYCLES(2)
  ) dut (
    .clk_i             (clk_i),
    .rst_i             (rst_i),
    .shift_en_s_i      (shift_en_s_i),
    .shift_en_r_i      (shift_en_r_i),
    .shift_dir_i       (shift_dir_i),
    .source_shift_sel_i(source_shift_sel_i),
    .n_shift_i         (n_shift_i),
    .shift_pulse_o     (shift_pulse_o),
    .shift_dir_o       (shift_dir_o),
    .shift_done_s_o    (shift_done_s_o),
    .shift_done_r_o    (shift_done_r_o),
    .busy_o            (busy_o),
    .pos_o             (pos_o),
    .err_o             (err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs != exp) begin
      n_failed++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // One clock, sampled 1 ns after the edge; tracks pulses and done
  task automatic tick();
    @(posedge clk_i);
    #1;
    if (shift_pulse_o && !prev_pulse) pulses++;
    if (shift_pulse_o) hi_cyc++;
    if (shift_done_s_o || shift_done_r_o) done_seen = 1'b1;
    prev_pulse = shift_pulse_o;
  endtask

  task automatic clr_stats();
    pulses    = 0;
    hi_cyc    = 0;
    done_seen = 1'b0;
  endtask

  task automatic start_op(input bit s, input bit r, input bit dir,
                          input bit sel, input int n);
    shift_en_s_i       = s;
    shift_en_r_i       = r;
    shift_dir_i        = dir;
    source_shift_sel_i = sel;
    n_shift_i          = CW'(n);
    clr_stats();
  endtask

  // Ticks until a done output is seen; the cycle count includes prior ticks
  task automatic wait_done(input int max_cyc);
    while (!(shift_done_s_o || shift_done_r_o) && cyc < max_cyc) begin
      tick();
      cyc++;
    end
    check_eq("done_within_budget", int'(shift_done_s_o || shift_done_r_o), 1);
  endtask

  initial begin
    rst_i = 1'b1;
    start_op(1'b0, 1'b0, 1'b0, 1'b0, 0);
    #1;
    check_eq("rst_pulse", int'(shift_pulse_o), 0);
    check_eq("rst_busy",  int'(busy_o), 0);
    check_eq("rst_pos",   int'(pos_o), 0);
    check_eq("rst_err",   int'(err_o), 0);
    check_eq("rst_done",  int'(shift_done_s_o | shift_done_r_o), 0);
    check_eq("rst_dir",   int'(shift_dir_o), 0);
    tick(); tick();
    rst_i = 1'b0;
    tick();

    // Set op n=3 forward
    start_op(1'b1, 1'b0, 1'b1, 1'b0, 3);
    cyc = 0;
    wait_done(40);
    check_eq("set3_cycles", cyc, 13);
    check_eq("set3_pulses", pulses, 3);
    check_eq("set3_hi_cyc", hi_cyc, 6);
    check_eq("set3_done_s", int'(shift_done_s_o), 1);
    check_eq("set3_pos",    int'(pos_o), 3);
    check_eq("set3_dir",    int'(shift_dir_o), 1);
    shift_en_s_i = 1'b0;
    tick();
    check_eq("set3_idle", int'(busy_o), 0);

    // Reset op from sampled count; direction input flips mid-op
    start_op(1'b0, 1'b1, 1'b0, 1'b1, 7);
    tick();
    shift_dir_i = 1'b1;
    cyc = 1;
    wait_done(40);
    check_eq("rst3_cycles", cyc, 13);
    check_eq("rst3_pulses", pulses, 3);
    check_eq("rst3_done_r", int'(shift_done_r_o), 1);
    check_eq("rst3_done_s", int'(shift_done_s_o), 0);
    check_eq("rst3_pos",    int'(pos_o), 0);
    check_eq("rst3_dir",    int'(shift_dir_o), 0);

    // Back-to-back: reset done -> set n=5 in the same cycle
    start_op(1'b1, 1'b0, 1'b1, 1'b0, 5);
    tick();
    check_eq("b2b_bubble_busy", int'(busy_o), 0);
    check_eq("b2b_bubble_done", int'(shift_done_r_o), 0);
    cyc = 1;
    wait_done(60);
    check_eq("b2b_cycles", cyc, 22);
    check_eq("b2b_pulses", pulses, 5);
    check_eq("b2b_done_s", int'(shift_done_s_o), 1);
    check_eq("b2b_pos",    int'(pos_o), 5);
    check_eq("b2b_err",    int'(err_o), 0);
    shift_en_s_i = 1'b0;
    tick();

    // Zero count
    start_op(1'b1, 1'b0, 1'b1, 1'b0, 0);
    cyc = 0;
    wait_done(10);
    check_eq("zero_cycles", cyc, 1);
    check_eq("zero_pulses", pulses, 0);
    check_eq("zero_pos",    int'(pos_o), 5);
    shift_en_s_i = 1'b0;
    tick();

    // Abort during second pulse high phase
    start_op(1'b1, 1'b0, 1'b1, 1'b0, 4);
    repeat (5) tick();
    check_eq("abort_in_hi2", int'(shift_pulse_o), 1);
    shift_en_s_i = 1'b0;
    repeat (3) tick();
    check_eq("abort_lo_busy", int'(busy_o), 1);
    tick();
    check_eq("abort_busy",   int'(busy_o), 0);
    check_eq("abort_pulses", pulses, 2);
    check_eq("abort_pos",    int'(pos_o), 7);
    check_eq("abort_err",    int'(err_o), 1);
    check_eq("abort_nodone", int'(done_seen), 0);

    // Asynchronous reset mid PULSE_HI
    start_op(1'b1, 1'b0, 1'b1, 1'b0, 3);
    tick(); tick();
    check_eq("arst_pre_pulse", int'(shift_pulse_o), 1);
    #2 rst_i = 1'b1;
    #1;
    check_eq("arst_pulse", int'(shift_pulse_o), 0);
    check_eq("arst_busy",  int'(busy_o), 0);
    check_eq("arst_pos",   int'(pos_o), 0);
    check_eq("arst_err",   int'(err_o), 0);
    shift_en_s_i = 1'b0;
    #2 rst_i = 1'b0;
    prev_pulse = 1'b0;
    @(posedge clk_i);
    #1;
    start_op(1'b1, 1'b0, 1'b1, 1'b0, 1);
    cyc = 0;
    wait_done(20);
    check_eq("post_rst_cycles", cyc, 5);
    check_eq("post_rst_pulses", pulses, 1);
    check_eq("post_rst_pos",    int'(pos_o), 1);
    shift_en_s_i = 1'b0;
    tick();

    // Conflicting enables: set wins, error flagged
    start_op(1'b1, 1'b1, 1'b1, 1'b0, 2);
    cyc = 0;
    wait_done(30);
    check_eq("conf_cycles", cyc, 9);
    check_eq("conf_pulses", pulses, 2);
    check_eq("conf_done_s", int'(shift_done_s_o), 1);
    check_eq("conf_done_r", int'(shift_done_r_o), 0);
    check_eq("conf_err",    int'(err_o), 1);
    check_eq("conf_pos",    int'(pos_o), 3);
    shift_en_s_i = 1'b0;
    shift_en_r_i = 1'b0;
    tick();
    check_eq("conf_idle", int'(busy_o), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_failed);
    $finish;
  end

endmodule
